wb_sram_bridge: RTL

Wishbone classic responder that serves the 16-bit core bus (the arbitrated instruction/data master) from an external asynchronous 8-bit SRAM. Each Wishbone word access is split into one or two byte cycles, selected by `wb_sel`, with a programmable number of strobe wait states. Out-of-range addresses terminate with `wb_err`. The block sits directly on the upper core's external Wishbone bus as the main-memory slave.

---
 rtl/wb_sram_bridge_pkg.sv | 18 +
 rtl/wb_sram_bridge_sram_byte_phase.sv | 36 +++
 rtl/wb_sram_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared constants and state encoding for the Wishbone-to-byte-SRAM bridge.
package wb_sram_bridge_pkg;

  localparam int WB_ADDR_W   = 24;
  localparam int WB_DATA_W   = 16;
  localparam int WB_SEL_BITS = 2;
  localparam int SRAM_DATA_W = 8;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/wb_sram_bridge_sram_byte_phase.sv
// Wait-state sequencer for one SRAM byte cycle. The counter is loaded with
// the wait count on phase entry and counts down; the strobe is active while
// the count is nonzero and the terminal count marks the final hold cycle.
module sram_byte_phase
  import wb_sram_bridge_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_active,
  input  logic [WAIT_CNT_W-1:0] i_wait,
  output logic                  o_strobe,
  output logic                  o_capture,
  output logic                  o_done
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // Down-counter: load on phase entry, count to zero, clear when idle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_wait;
    end else if (i_active && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (!i_active) begin
      r_cnt <= '0;
    end
  end

  assign o_strobe  = i_active && (r_cnt != '0);
  assign o_capture = i_active && (r_cnt == WAIT_CNT_W'(1));
  assign o_done    = i_active && (r_cnt == '0);

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone classic responder serving 16-bit words from an 8-bit async SRAM.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for cyc&stb; range and byte-select decode
//   LO    | byte cycle on lane 0 (sram_a = {word,0})
//   HI    | byte cycle on lane 1 (sram_a = {word,1})
//   RESP  | wb_ack pulse
//   ERR   | wb_err pulse (address beyond implemented SRAM)
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int SIZE_W = 20,
  parameter int WAIT   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_adr,
  input  logic [WB_DATA_W-1:0]   wb_i_dat,
  input  logic [WB_SEL_BITS-1:0] wb_sel,
  output logic [WB_DATA_W-1:0]   wb_o_dat,
  output logic                   wb_ack,
  output logic                   wb_err,
  output logic                   wb_rty,
  output logic [SIZE_W:0]        sram_a,
  output logic [SRAM_DATA_W-1:0] sram_d_o,
  input  logic [SRAM_DATA_W-1:0] sram_d_i,
  output logic                   sram_d_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT);

  bridge_state_t          r_state;
  bridge_state_t          w_state_nxt;
  logic                   w_req;
  logic                   w_adr_oor;
  logic                   w_accept;
  logic                   w_active;
  logic                   w_start;
  logic                   w_strobe;
  logic                   w_capture;
  logic                   w_done;
  logic [SIZE_W-1:0]      r_adr;
  logic [SIZE_W-1:0]      w_adr_src;
  logic [SRAM_DATA_W-1:0] r_dat_hi;
  logic [SRAM_DATA_W-1:0] w_dat_hi_src;
  logic                   r_we;
  logic                   r_sel_hi;
  logic [SIZE_W:0]        r_sram_a;
  logic [SRAM_DATA_W-1:0] r_sram_d_o;
  logic [WB_DATA_W-1:0]   r_o_dat;
  logic                   r_ack;
  logic                   r_err;

  assign w_req     = wb_cyc & wb_stb;
  assign w_adr_oor = |(wb_adr >> SIZE_W);
  assign w_accept  = (r_state == ST_IDLE) && w_req;
  assign w_active  = (r_state == ST_LO) || (r_state == ST_HI);

  // In IDLE the request is not yet latched, so the first phase takes
  // address and data straight from the bus.
  assign w_adr_src    = (r_state == ST_IDLE) ? wb_adr[SIZE_W-1:0] : r_adr;
  assign w_dat_hi_src = (r_state == ST_IDLE) ? wb_i_dat[15:8] : r_dat_hi;

  assign w_start = ((w_state_nxt == ST_LO) && (r_state != ST_LO)) ||
                   ((w_state_nxt == ST_HI) && (r_state != ST_HI));

  sram_byte_phase u_phase (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_active  (w_active),
    .i_wait    (WAIT_CNT),
    .o_strobe  (w_strobe),
    .o_capture (w_capture),
    .o_done    (w_done)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a dropped cycle abandons the byte phase silently.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_adr_oor)           w_state_nxt = ST_ERR;
          else if (wb_sel == '0)   w_state_nxt = ST_RESP;
          else if (wb_sel[0])      w_state_nxt = ST_LO;
          else                     w_state_nxt = ST_HI;
        end
      end
      ST_LO: begin
        if (!wb_cyc)     w_state_nxt = ST_IDLE;
        else if (w_done) w_state_nxt = r_sel_hi ? ST_HI : ST_RESP;
      end
      ST_HI: begin
        if (!wb_cyc)     w_state_nxt = ST_IDLE;
        else if (w_done) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and per-phase SRAM address/data, held for the whole phase.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_adr      <= '0;
      r_dat_hi   <= '0;
      r_we       <= 1'b0;
      r_sel_hi   <= 1'b0;
      r_sram_a   <= '0;
      r_sram_d_o <= '0;
    end else begin
      if (w_accept) begin
        r_adr    <= wb_adr[SIZE_W-1:0];
        r_dat_hi <= wb_i_dat[15:8];
        r_we     <= wb_we;
        r_sel_hi <= wb_sel[1];
      end
      if (w_start) begin
        r_sram_a   <= {w_adr_src, (w_state_nxt == ST_HI)};
        r_sram_d_o <= (w_state_nxt == ST_HI) ? w_dat_hi_src : wb_i_dat[7:0];
      end
    end
  end

  // Read data: cleared per request so unselected lanes read as zero, each
  // lane captured on its last strobe-low cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_o_dat <= '0;
    end else if (w_accept) begin
      r_o_dat <= '0;
    end else if (w_capture && !r_we) begin
      if (r_state == ST_LO) r_o_dat[7:0]  <= sram_d_i;
      else                  r_o_dat[15:8] <= sram_d_i;
    end
  end

  // Termination pulses, registered so they coincide with RESP/ERR.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= (w_state_nxt == ST_RESP);
      r_err <= (w_state_nxt == ST_ERR);
    end
  end

  assign wb_o_dat  = r_o_dat;
  assign wb_ack    = r_ack;
  assign wb_err    = r_err;
  assign wb_rty    = 1'b0;
  assign sram_a    = r_sram_a;
  assign sram_d_o  = r_sram_d_o;
  assign sram_d_oe = w_active && r_we;
  assign sram_ce_n = !w_active;
  assign sram_we_n = !(w_strobe && r_we);
  assign sram_oe_n = !(w_strobe && !r_we);

endmodule
